// File: rtl/clct_sort_sequencer_pkg.sv
// Shared widths, FSM state encoding and key arithmetic for the two-pass CLCT sorter.
package clct_sort_sequencer_pkg;

  localparam int MXCFEB     = 7;
  localparam int MXPATB     = 7;
  localparam int MXKEYB     = 5;
  localparam int MXKEYBX    = 8;
  localparam int SPREAD_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              vld;
    logic [MXPATB-1:0] pat;
    logic [MXKEYBX-1:0] key;
  } clct_t;

  function automatic logic [MXKEYBX-1:0] full_key(input logic [2:0] cfeb,
                                                  input logic [MXKEYB-1:0] key);
    return {cfeb, key};
  endfunction

  // One extra bit of headroom so the subtraction never wraps.
  function automatic logic [MXKEYBX:0] key_dist(input logic [MXKEYBX:0] a,
                                                input logic [MXKEYBX:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clct_sort_sequencer_best_of7_sort.sv
// Combinational best-of-7 pattern sort on pat[6:1]; ties resolve to the higher CFEB.
// An all-zero candidate set reports CFEB0 with its own key and vld=0.
module best_of7_sort
  import clct_sort_sequencer_pkg::*;
(
  input  logic [MXCFEB*MXPATB-1:0] pat_i,
  input  logic [MXCFEB*MXKEYB-1:0] key_i,
  output clct_t                    best_o,
  output logic [2:0]               cfeb_o
);

  logic [2:0]        best_idx;
  logic [MXPATB-1:0] best_pat;

  always_comb begin
    best_idx = 3'd6;
    best_pat = pat_i[6*MXPATB +: MXPATB];
    // Walking downward with a strict compare leaves ties on the higher index.
    for (int n = MXCFEB-2; n >= 0; n--) begin
      if (pat_i[n*MXPATB+1 +: MXPATB-1] > best_pat[MXPATB-1:1]) begin
        best_idx = 3'(n);
        best_pat = pat_i[n*MXPATB +: MXPATB];
      end
    end
    if (pat_i == '0) begin
      best_idx = 3'd0;
      best_pat = '0;
    end
    cfeb_o     = best_idx;
    best_o.vld = (best_pat != '0);
    best_o.pat = best_pat;
    best_o.key = full_key(best_idx, key_i[best_idx*MXKEYB +: MXKEYB]);
  end

endmodule

// File: rtl/clct_sort_sequencer.sv
// Two-pass CLCT sorter: pass 0 finds CLCT0, pass 1 re-sorts with the CLCT0 key
// neighbourhood blanked to find CLCT1. One set per 4 clocks; result held until out_ready.
module clct_sort_sequencer
  import clct_sort_sequencer_pkg::*;
#(
  parameter int SPREAD = SPREAD_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MXCFEB*MXPATB-1:0]   in_pat,
  input  logic [MXCFEB*MXKEYB-1:0]   in_key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       clct0_vld,
  output logic [MXPATB-1:0]          clct0_pat,
  output logic [MXKEYBX-1:0]         clct0_key,
  output logic                       clct1_vld,
  output logic [MXPATB-1:0]          clct1_pat,
  output logic [MXKEYBX-1:0]         clct1_key,
  output logic [15:0]                lost_cnt
);

  localparam logic [MXKEYBX:0] SPREAD_W = SPREAD[MXKEYBX:0];

  state_e                    state_q, state_d;
  logic [MXCFEB*MXPATB-1:0]  cap_pat_q, cap_pat_d;
  logic [MXCFEB*MXKEYB-1:0]  cap_key_q, cap_key_d;
  logic [MXCFEB-1:0]         mask_q, mask_d;
  clct_t                     clct0_q, clct0_d;
  clct_t                     clct1_q, clct1_d;
  logic [15:0]               lost_q, lost_d;

  logic [MXCFEB*MXPATB-1:0]  sort_pat;
  logic [MXCFEB-1:0]         blank;
  clct_t                     srt;
  logic [2:0]                srt_cfeb;

  // Pass-select mux: the blank mask only applies to the second pass.
  always_comb begin
    sort_pat = cap_pat_q;
    blank    = '0;
    for (int n = 0; n < MXCFEB; n++) begin
      if (state_q == ST_PASS1 && mask_q[n]) begin
        sort_pat[n*MXPATB +: MXPATB] = '0;
      end
      blank[n] = srt.vld &&
                 ((key_dist({1'b0, full_key(3'(n), cap_key_q[n*MXKEYB +: MXKEYB])},
                            {1'b0, srt.key}) <= SPREAD_W) ||
                  (srt_cfeb == 3'(n)));
    end
  end

  best_of7_sort u_sort (
    .pat_i  (sort_pat),
    .key_i  (cap_key_q),
    .best_o (srt),
    .cfeb_o (srt_cfeb)
  );

  always_comb begin
    state_d   = state_q;
    cap_pat_d = cap_pat_q;
    cap_key_d = cap_key_q;
    mask_d    = mask_q;
    clct0_d   = clct0_q;
    clct1_d   = clct1_q;
    lost_d    = lost_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cap_pat_d = in_pat;
          cap_key_d = in_key;
          mask_d    = '0;
          state_d   = ST_PASS0;
        end
      end
      ST_PASS0: begin
        clct0_d = srt;
        mask_d  = blank;
        state_d = ST_PASS1;
      end
      ST_PASS1: begin
        clct1_d = srt;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A set offered while busy is dropped, including on the DONE->IDLE cycle.
    if (in_valid && (state_q != ST_IDLE) && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cap_pat_q <= '0;
      cap_key_q <= '0;
      mask_q    <= '0;
      clct0_q   <= '0;
      clct1_q   <= '0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      cap_pat_q <= cap_pat_d;
      cap_key_q <= cap_key_d;
      mask_q    <= mask_d;
      clct0_q   <= clct0_d;
      clct1_q   <= clct1_d;
      lost_q    <= lost_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign clct0_vld = clct0_q.vld;
  assign clct0_pat = clct0_q.pat;
  assign clct0_key = clct0_q.key;
  assign clct1_vld = clct1_q.vld;
  assign clct1_pat = clct1_q.pat;
  assign clct1_key = clct1_q.key;
  assign lost_cnt  = lost_q;

endmodule
